// File: rtl/clkmeas.sv
// Half-period meter: counts clk cycles between transitions of an asynchronous
// square wave and reports the count in the clock divider's lim encoding.
module clkmeas #(
  parameter int BITLEN      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sig_in,
  output logic [BITLEN-1:0] lim_out,
  output logic              valid,
  output logic              ovf,
  output logic              locked,
  output logic              busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] MEAS = 2'd2;
  localparam logic [1:0] OVF  = 2'd3;

  localparam logic [BITLEN-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   s_d;
  logic                   edge_det;
  logic [BITLEN-1:0]      cnt;
  logic [BITLEN-1:0]      prev;
  logic                   have_prev;
  logic [1:0]             state;

  assign s        = sync[SYNC_STAGES-1];
  assign edge_det = s ^ s_d;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync      <= '0;
      s_d       <= 1'b0;
      cnt       <= '0;
      prev      <= '0;
      have_prev <= 1'b0;
      lim_out   <= '0;
      valid     <= 1'b0;
      ovf       <= 1'b0;
      locked    <= 1'b0;
      state     <= IDLE;
    end else begin
      // NOTE: non-blocking assignments let every flop see last cycle's values,
      // so the shift chain and the later overrides below behave as registers.
      sync  <= {sync[SYNC_STAGES-2:0], sig_in};
      s_d   <= s;
      valid <= 1'b0;
      ovf   <= 1'b0;

      if (!en) begin
        // Enable wins over any edge this cycle; lim_out and locked hold.
        state     <= IDLE;
        cnt       <= '0;
        have_prev <= 1'b0;
      end else begin
        if (edge_det)
          cnt <= '0;
        else if (cnt != CNT_MAX)
          cnt <= cnt + 1'b1;

        case (state)
          IDLE: begin
            cnt   <= '0;
            state <= ARM;
          end
          ARM: begin
            if (edge_det)
              state <= MEAS;
          end
          MEAS: begin
            // An edge landing on the saturated count is still a valid all-ones result.
            if (edge_det) begin
              lim_out   <= cnt;
              valid     <= 1'b1;
              locked    <= have_prev && (cnt == prev);
              prev      <= cnt;
              have_prev <= 1'b1;
            end else if (cnt == CNT_MAX) begin
              state <= OVF;
            end
          end
          OVF: begin
            if (edge_det) begin
              ovf       <= 1'b1;
              locked    <= 1'b0;
              have_prev <= 1'b0;
              state     <= MEAS;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clkmeas.sv
// Self-checking bench for clkmeas: a cycle-stamped model pushes expected
// measurements into per-instance queues, a negedge monitor pops them on valid.
`timescale 1ns/1ps
module tb_clkmeas;

  typedef struct {
    int lim;
    bit lk;
  } exp_t;

  typedef struct {
    int half;
    int edges;
    int lim;
    bit lk;
  } row_t;

  logic       clk;
  logic       rst;
  logic       en8, en4;
  logic       sig8, sig4;
  logic [7:0] lim_out8;
  logic [3:0] lim_out4;
  logic       valid8, ovf8, locked8, busy8;
  logic       valid4, ovf4, locked4, busy4;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  exp_t q8[$];
  exp_t q4[$];
  exp_t ex8, ex4;
  int   ovf_exp8 = 0, ovf_exp4 = 0;
  bit   armed8 = 0, armed4 = 0;
  bit   hp8 = 0, hp4 = 0;
  int   prev8 = 0, prev4 = 0;
  int   last8 = 0, last4 = 0;

  row_t rows[11];

  clkmeas #(.BITLEN(8), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .sig_in(sig8),
    .lim_out(lim_out8), .valid(valid8), .ovf(ovf8), .locked(locked8), .busy(busy8)
  );

  clkmeas #(.BITLEN(4), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .sig_in(sig4),
    .lim_out(lim_out4), .valid(valid4), .ovf(ovf4), .locked(locked4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Reference: the gap between toggles in clk cycles is the half-period.
  task automatic model_edge(input int which);
    exp_t e;
    int   gap;
    if (which == 8) begin
      gap   = cyc - last8;
      last8 = cyc;
      if (!armed8) armed8 = 1;
      else if (gap <= 256) begin
        e.lim = gap - 1; e.lk = hp8 && (prev8 == gap - 1);
        q8.push_back(e); prev8 = gap - 1; hp8 = 1;
      end else begin
        ovf_exp8++; hp8 = 0;
      end
    end else begin
      gap   = cyc - last4;
      last4 = cyc;
      if (!armed4) armed4 = 1;
      else if (gap <= 16) begin
        e.lim = gap - 1; e.lk = hp4 && (prev4 == gap - 1);
        q4.push_back(e); prev4 = gap - 1; hp4 = 1;
      end else begin
        ovf_exp4++; hp4 = 0;
      end
    end
  endtask

  task automatic drive(input int which, input int half, input int n);
    for (int i = 0; i < n; i++) begin
      if (which == 8) sig8 = ~sig8; else sig4 = ~sig4;
      model_edge(which);
      repeat (half) @(posedge clk);
      #1;
    end
  endtask

  // NOTE: outputs are sampled on the falling edge, half a cycle clear of the
  // rising edge that updates them.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid8 || ovf8) check("dut8 valid/ovf exclusive", {31'd0, valid8 & ovf8}, 0);
      if (valid8) begin
        if (q8.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL dut8 unexpected valid: lim_out=%0d, none due", lim_out8);
        end else begin
          ex8 = q8.pop_front();
          check("dut8 lim_out", {24'd0, lim_out8}, ex8.lim);
          check("dut8 locked", {31'd0, locked8}, {31'd0, ex8.lk});
        end
      end
      if (ovf8) begin
        n_vec++;
        if (ovf_exp8 == 0) begin
          n_err++; $display("FAIL dut8 unexpected ovf: ovf=1, none due");
        end else ovf_exp8--;
        check("dut8 locked on ovf", {31'd0, locked8}, 0);
      end
      if (valid4 || ovf4) check("dut4 valid/ovf exclusive", {31'd0, valid4 & ovf4}, 0);
      if (valid4) begin
        if (q4.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL dut4 unexpected valid: lim_out=%0d, none due", lim_out4);
        end else begin
          ex4 = q4.pop_front();
          check("dut4 lim_out", {28'd0, lim_out4}, ex4.lim);
          check("dut4 locked", {31'd0, locked4}, {31'd0, ex4.lk});
        end
      end
      if (ovf4) begin
        n_vec++;
        if (ovf_exp4 == 0) begin
          n_err++; $display("FAIL dut4 unexpected ovf: ovf=1, none due");
        end else ovf_exp4--;
        check("dut4 locked on ovf", {31'd0, locked4}, 0);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Each row's first toggle closes the previous row's half-period, so the
    // expected lim/locked after a row reflects the gaps ending inside it.
    rows[0]  = '{half: 6,   edges: 4, lim: 5,   lk: 1};
    rows[1]  = '{half: 7,   edges: 1, lim: 5,   lk: 1};
    rows[2]  = '{half: 6,   edges: 1, lim: 6,   lk: 0};
    rows[3]  = '{half: 7,   edges: 1, lim: 5,   lk: 0};
    rows[4]  = '{half: 6,   edges: 1, lim: 6,   lk: 0};
    rows[5]  = '{half: 7,   edges: 1, lim: 5,   lk: 0};
    rows[6]  = '{half: 6,   edges: 3, lim: 5,   lk: 1};
    rows[7]  = '{half: 256, edges: 2, lim: 255, lk: 0};
    rows[8]  = '{half: 257, edges: 1, lim: 255, lk: 1};
    rows[9]  = '{half: 6,   edges: 2, lim: 5,   lk: 0};
    rows[10] = '{half: 6,   edges: 1, lim: 5,   lk: 1};

    rst = 1'b1; en8 = 1'b0; en4 = 1'b0; sig8 = 1'b0; sig4 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset lim_out", {24'd0, lim_out8}, 0);
    check("reset valid", {31'd0, valid8}, 0);
    check("reset ovf", {31'd0, ovf8}, 0);
    check("reset locked", {31'd0, locked8}, 0);
    check("reset busy", {31'd0, busy8}, 0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("idle busy with en low", {31'd0, busy8}, 0);
    en8 = 1'b1; en4 = 1'b1;
    @(posedge clk); @(negedge clk);
    check("busy after enable", {31'd0, busy8}, 1);
    check("dut4 busy after enable", {31'd0, busy4}, 1);

    for (int i = 0; i < 11; i++) begin
      drive(8, rows[i].half, rows[i].edges);
      @(negedge clk);
      check($sformatf("row%0d lim_out", i), {24'd0, lim_out8}, rows[i].lim);
      check($sformatf("row%0d locked", i), {31'd0, locked8}, {31'd0, rows[i].lk});
    end
    check("ovf count after table", ovf_exp8, 0);

    // en dropped in the middle of a half-period
    sig8 = ~sig8; model_edge(8);
    repeat (4) @(posedge clk);
    #1 en8 = 1'b0;
    @(posedge clk); @(negedge clk);
    check("busy falls on en drop", {31'd0, busy8}, 0);
    armed8 = 0; hp8 = 0;
    repeat (2) begin
      repeat (6) @(posedge clk);
      #1 sig8 = ~sig8;
    end
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("lim_out holds while disabled", {24'd0, lim_out8}, 5);
    check("locked holds while disabled", {31'd0, locked8}, 1);
    en8 = 1'b1;
    drive(8, 6, 3);
    @(negedge clk);
    check("re-enable lim_out", {24'd0, lim_out8}, 5);

    // en dropped in the same cycle the edge reaches the FSM
    sig8 = ~sig8;
    @(posedge clk); @(posedge clk);
    #1 en8 = 1'b0;
    @(posedge clk); @(negedge clk);
    check("busy falls on en/edge clash", {31'd0, busy8}, 0);
    check("lim_out holds on en/edge clash", {24'd0, lim_out8}, 5);
    armed8 = 0; hp8 = 0;
    en8 = 1'b1;
    drive(8, 6, 2);
    @(negedge clk);
    check("clash re-enable locked", {31'd0, locked8}, 0);

    // asynchronous reset mid-measurement
    drive(8, 6, 1);
    @(negedge clk);
    check("pre-reset locked", {31'd0, locked8}, 1);
    check("pre-reset queue empty", q8.size(), 0);
    #2 rst = 1'b1; sig8 = 1'b0;
    #1;
    check("async reset lim_out", {24'd0, lim_out8}, 0);
    check("async reset valid", {31'd0, valid8}, 0);
    check("async reset ovf", {31'd0, ovf8}, 0);
    check("async reset locked", {31'd0, locked8}, 0);
    check("async reset busy", {31'd0, busy8}, 0);
    armed8 = 0; hp8 = 0; armed4 = 0; hp4 = 0;
    @(negedge clk) rst = 1'b0;
    drive(8, 6, 2);
    @(negedge clk);
    check("post-reset lim_out", {24'd0, lim_out8}, 5);

    // sig_in toggling every clk
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 sig8 = ~sig8;
      model_edge(8);
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("half-period 1 lim_out", {24'd0, lim_out8}, 0);
    check("half-period 1 locked", {31'd0, locked8}, 1);

    // 4-bit counter: overflow, then exactly-saturating half-period
    drive(4, 5, 3);
    drive(4, 20, 4);
    @(negedge clk);
    check("dut4 lim_out kept through ovf", {28'd0, lim_out4}, 4);
    check("dut4 locked after ovf", {31'd0, locked4}, 0);
    drive(4, 16, 2);
    drive(4, 16, 1);
    @(negedge clk);
    check("dut4 saturated lim_out", {28'd0, lim_out4}, 15);
    check("dut4 saturated locked", {31'd0, locked4}, 1);

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("dut8 expected valids drained", q8.size(), 0);
    check("dut4 expected valids drained", q4.size(), 0);
    check("dut8 expected ovfs drained", ovf_exp8, 0);
    check("dut4 expected ovfs drained", ovf_exp4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
